// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: PmodJSTK-style SPI slave serving X/Y/buttons, LED command capture; JSTK_MISO_TRISTATE_EN releases MISO outside frames
module jstk_spi_responder (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SS,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [9:0] X_POS,
   input  logic [9:0] Y_POS,
   input  logic [2:0] BTN,
   output logic [1:0] LED,
   output logic       BUSY,
   output logic       FRAME_DONE,
   output logic       FRAME_ERR
);
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, XFER} state_t;
   state_t state, state_nxt;
   logic [1:0] ss_sy, sclk_sy, mosi_sy;
   logic ss_d, sclk_d;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;
   logic [39:0] tx;
   logic [7:0] rx, cmd;
   logic [5:0] cnt;
   logic frame_start, frame_end;
   assign ss_fall = ss_d & ~ss_sy[1];
   assign ss_rise = ~ss_d & ss_sy[1];
   assign sclk_rise = ~sclk_d & sclk_sy[1];
   assign sclk_fall = sclk_d & ~sclk_sy[1];
   assign frame_start = (state == IDLE) & ss_fall;
   assign frame_end = (state == XFER) & ss_rise;
   assign BUSY = (state == XFER);
`ifdef JSTK_MISO_TRISTATE_EN
   assign MISO = BUSY ? tx[39] : 1'bz;
`else
   assign MISO = BUSY & tx[39];
`endif
   // two-flop synchronizers plus one delayed copy for edge detection
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         ss_sy <= 2'b00;
         sclk_sy <= 2'b00;
         mosi_sy <= 2'b00;
         ss_d <= 1'b0;
         sclk_d <= 1'b0;
      end else begin
         ss_sy <= {ss_sy[0], SS};
         sclk_sy <= {sclk_sy[0], SCLK};
         mosi_sy <= {mosi_sy[0], MOSI};
         ss_d <= ss_sy[1];
         sclk_d <= sclk_sy[1];
      end
   // state register
   always_ff @(posedge CLK or negedge RST)
      if (!RST) state <= WAIT_IDLE;
      else state <= state_nxt;
   // next state: wait for SS high after reset so no frame starts mid-transfer
   always_comb begin
      state_nxt = state;
      if (state == WAIT_IDLE && ss_sy[1]) state_nxt = IDLE;
      else if (frame_start) state_nxt = XFER;
      else if (frame_end) state_nxt = IDLE;
   end
   // frame datapath: snapshot, shift, command capture and end-of-frame verdict
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         tx <= '0;
         rx <= '0;
         cmd <= '0;
         cnt <= '0;
         LED <= 2'b00;
         FRAME_DONE <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         FRAME_ERR <= 1'b0;
         if (frame_start) begin
            tx <= {X_POS[7:0], 6'b0, X_POS[9:8], Y_POS[7:0], 6'b0, Y_POS[9:8], 5'b0, BTN};
            cnt <= '0;
         end else if (frame_end) begin
            if (cnt == 6'd40 && cmd[7:2] == 6'b100000) begin
               FRAME_DONE <= 1'b1;
               LED <= cmd[1:0];
            end else FRAME_ERR <= 1'b1;
         end else if (BUSY && sclk_rise) begin
            rx <= {rx[6:0], mosi_sy[1]};
            cnt <= (cnt == 6'd41) ? cnt : cnt + 6'd1;
            if (cnt == 6'd7) cmd <= {rx[6:0], mosi_sy[1]};
         end else if (BUSY && sclk_fall) tx <= {tx[38:0], 1'b0};
      end
endmodule
